// File: rtl/cordic_sincos_ctrl_pkg.sv
// cordic_sincos_ctrl_pkg: shared CORDIC constants (Q3.30 angles, mode encoding)
package cordic_sincos_ctrl_pkg;
    localparam int PI_FRAC = 30;
    localparam logic signed [63:0] PI      = 64'sd3373259426;
    localparam logic signed [63:0] PI_HALF = 64'sd1686629713;
    typedef enum logic [1:0] {
        MODE_LIN  = 2'b00,
        MODE_CIRC = 2'b01,
        MODE_HYP  = 2'b11
    } cd_mode_e;
endpackage

// File: rtl/cordic_sincos_ctrl_if.sv
// cordic_sincos_ctrl_if: request, CORDIC job/result and result buses of the sin/cos controller
//   slave  : controller view (takes requests and CORDIC results, drives jobs and results)
//   master : environment view (issues requests, plays the CORDIC, consumes results)
interface cordic_sincos_ctrl_if #(
    parameter int BITS  = 33,
    parameter int TAG_W = 4
);
    logic                    i_valid;
    logic signed [BITS-1:0]  i_angle;
    logic [TAG_W-1:0]        i_tag;
    logic                    o_ready;
    logic                    o_cd_valid;
    logic signed [BITS-1:0]  o_cd_x;
    logic signed [BITS-1:0]  o_cd_y;
    logic signed [BITS-1:0]  o_cd_z;
    logic [1:0]              o_cd_mode;
    logic                    o_cd_rot_en;
    logic                    i_cd_valid;
    logic signed [BITS-1:0]  i_cd_x;
    logic signed [BITS-1:0]  i_cd_y;
    logic [1:0]              i_cd_mode;
    logic                    i_cd_rot_en;
    logic                    o_valid;
    logic signed [BITS-1:0]  o_cos;
    logic signed [BITS-1:0]  o_sin;
    logic [TAG_W-1:0]        o_tag;
    logic                    i_ready;
    logic                    o_err;
    modport slave (
        input  i_valid, i_angle, i_tag, i_cd_valid, i_cd_x, i_cd_y, i_cd_mode, i_cd_rot_en, i_ready,
        output o_ready, o_cd_valid, o_cd_x, o_cd_y, o_cd_z, o_cd_mode, o_cd_rot_en,
               o_valid, o_cos, o_sin, o_tag, o_err
    );
    modport master (
        output i_valid, i_angle, i_tag, i_cd_valid, i_cd_x, i_cd_y, i_cd_mode, i_cd_rot_en, i_ready,
        input  o_ready, o_cd_valid, o_cd_x, o_cd_y, o_cd_z, o_cd_mode, o_cd_rot_en,
               o_valid, o_cos, o_sin, o_tag, o_err
    );
endinterface

// File: rtl/cordic_sync_fifo.sv
// cordic_sync_fifo: show-ahead synchronous FIFO
//   i_push/i_data write, i_pop consumes the head shown on o_data; o_full/o_empty/o_count status.
//   A push while full is taken only when a pop frees the slot in the same cycle.
module cordic_sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 16
) (
    input  logic                     i_clk,
    input  logic                     i_rst,
    input  logic                     i_push,
    input  logic [WIDTH-1:0]         i_data,
    input  logic                     i_pop,
    output logic [WIDTH-1:0]         o_data,
    output logic                     o_full,
    output logic                     o_empty,
    output logic [$clog2(DEPTH):0]   o_count
);
    localparam int AW = $clog2(DEPTH);
    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wptr, rptr;
    logic             wr, rd;
    assign o_full  = o_count == (AW+1)'(DEPTH);
    assign o_empty = o_count == '0;
    assign wr      = i_push && (!o_full || i_pop);
    assign rd      = i_pop && !o_empty;
    assign o_data  = mem[rptr];
    always_ff @(posedge i_clk) begin
        if (wr) mem[wptr] <= i_data;
    end
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            wptr    <= '0;
            rptr    <= '0;
            o_count <= '0;
        end else begin
            wptr    <= wptr + AW'(wr);
            rptr    <= rptr + AW'(rd);
            o_count <= o_count + (AW+1)'(wr) - (AW+1)'(rd);
        end
    end
endmodule

// File: rtl/cordic_sincos_ctrl.sv
// cordic_sincos_ctrl: flow-controlled sin/cos front/back end around a fixed-latency CORDIC
//   i_clk, i_rst : clock, synchronous active-high reset (shared with the CORDIC pipeline)
//   bus          : request (i_valid/i_angle/i_tag/o_ready), CORDIC job (o_cd_*),
//                  CORDIC result (i_cd_*), result (o_valid/o_cos/o_sin/o_tag/i_ready), sticky o_err
module cordic_sincos_ctrl
    import cordic_sincos_ctrl_pkg::*;
#(
    parameter int BITS      = 33,
    parameter int FRAC      = 30,
    parameter int TAG_W     = 4,
    parameter int OUT_DEPTH = 16
) (
    input logic               i_clk,
    input logic               i_rst,
    cordic_sincos_ctrl_if.slave bus
);
    localparam int CW = $clog2(OUT_DEPTH + 1);
    localparam int SW = 1 + TAG_W;
    localparam int RW = 2 * BITS + TAG_W;
    localparam int QW = $clog2(OUT_DEPTH) + 1;
    localparam logic signed [BITS-1:0] PI_Q  = BITS'(PI >>> (PI_FRAC - FRAC));
    localparam logic signed [BITS-1:0] PIH_Q = BITS'(PI_HALF >>> (PI_FRAC - FRAC));
    logic [CW-1:0]          credits;
    logic                   accept, gt, lt, neg, cd_ok, ret, bad, res_pop;
    logic signed [BITS-1:0] z_red, cd_z, cos_c, sin_c, h_cos, h_sin;
    logic                   cd_valid, err;
    logic [SW-1:0]          sb_q;
    logic [RW-1:0]          res_q;
    logic [TAG_W-1:0]       h_tag;
    logic                   sb_full, sb_empty, res_full, res_empty;
    logic [QW-1:0]          sb_count, res_count;
    // Range reduction: anything beyond +-pi/2 is shifted by pi and flagged for sign correction.
    always_comb begin
        gt    = bus.i_angle > PIH_Q;
        lt    = bus.i_angle < -PIH_Q;
        neg   = gt || lt;
        z_red = gt ? bus.i_angle - PI_Q : lt ? bus.i_angle + PI_Q : bus.i_angle;
    end
    assign bus.o_ready = (credits != '0) && !i_rst;
    assign accept      = bus.i_valid && bus.o_ready;
    assign res_pop     = !res_empty && bus.i_ready;
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            credits  <= CW'(OUT_DEPTH);
            cd_valid <= 1'b0;
            cd_z     <= '0;
        end else begin
            credits  <= credits - CW'(accept) + CW'(res_pop);
            cd_valid <= accept;
            if (accept) cd_z <= z_red;
        end
    end
    assign bus.o_cd_valid  = cd_valid;
    assign bus.o_cd_z      = cd_z;
    assign bus.o_cd_x      = '0;
    assign bus.o_cd_y      = '0;
    assign bus.o_cd_mode   = MODE_CIRC;
    assign bus.o_cd_rot_en = 1'b1;
    // A returning result is only trusted if it matches an issued job and came back in rotation mode.
    assign cd_ok = bus.i_cd_mode == MODE_CIRC && bus.i_cd_rot_en;
    assign ret   = bus.i_cd_valid && !sb_empty && cd_ok;
    assign bad   = bus.i_cd_valid && (sb_empty || !cd_ok);
    assign cos_c = sb_q[TAG_W] ? -bus.i_cd_x : bus.i_cd_x;
    assign sin_c = sb_q[TAG_W] ? -bus.i_cd_y : bus.i_cd_y;
    always_ff @(posedge i_clk) begin
        if (i_rst) err <= 1'b0;
        else if (bad) err <= 1'b1;
    end
    assign bus.o_err = err;
    cordic_sync_fifo #(.WIDTH(SW), .DEPTH(OUT_DEPTH)) u_sb (
        .i_clk   (i_clk),
        .i_rst   (i_rst),
        .i_push  (accept),
        .i_data  ({neg, bus.i_tag}),
        .i_pop   (ret),
        .o_data  (sb_q),
        .o_full  (sb_full),
        .o_empty (sb_empty),
        .o_count (sb_count)
    );
    cordic_sync_fifo #(.WIDTH(RW), .DEPTH(OUT_DEPTH)) u_res (
        .i_clk   (i_clk),
        .i_rst   (i_rst),
        .i_push  (ret),
        .i_data  ({cos_c, sin_c, sb_q[TAG_W-1:0]}),
        .i_pop   (res_pop),
        .o_data  (res_q),
        .o_full  (res_full),
        .o_empty (res_empty),
        .o_count (res_count)
    );
    assign {h_cos, h_sin, h_tag} = res_q;
    // Head is masked while empty so the outputs read 0 after reset rather than stale memory.
    assign bus.o_valid = !res_empty;
    assign bus.o_cos   = res_empty ? '0 : h_cos;
    assign bus.o_sin   = res_empty ? '0 : h_sin;
    assign bus.o_tag   = res_empty ? '0 : h_tag;
    // Every credit is either free, an in-flight job, or a stored result.
    a_credit: assert property (@(posedge i_clk) disable iff (i_rst)
        32'(credits) + 32'(sb_count) + 32'(res_count) == OUT_DEPTH);
    a_sb_room: assert property (@(posedge i_clk) disable iff (i_rst) !(accept && sb_full));
    a_res_room: assert property (@(posedge i_clk) disable iff (i_rst) !(ret && res_full && !res_pop));
endmodule

// File: doc/cordic_sincos_ctrl.md
# cordic_sincos_ctrl

Front-end/back-end controller that turns the fixed-latency CORDIC pipeline into a flow-controlled sin/cos unit. It accepts angles over a valid/ready interface, range-reduces them into the CORDIC convergence range, and issues circular-rotation jobs. It tracks per-job sideband (quadrant flag, tag), applies the sign correction to returning results, and buffers them in an output FIFO. A credit counter guarantees the non-stallable CORDIC pipeline never overflows that FIFO.

## Interface
Parameters:
- BITS, 33: word width, signed Q3.30.
- FRAC, 30: fractional bits.
- TAG_W, 4: user tag width.
- OUT_DEPTH, 16: result FIFO depth (power of two, ≥2); also the sideband FIFO depth and the credit count.

Ports:
- i_clk  in  1  clock
- i_rst  in  1  reset, synchronous, active-high. Also drives the CORDIC pipeline's reset.
- i_valid  in  1  angle request valid
- i_angle  in  BITS  angle in radians, Q3.30, full range [-4, 4)
- i_tag  in  TAG_W  user tag, returned with the result
- o_ready  out  1  request accepted when i_valid && o_ready
- o_cd_valid  out  1  CORDIC input valid (to its i_ready)
- o_cd_x / o_cd_y  out  BITS  driven 0
- o_cd_z  out  BITS  reduced angle
- o_cd_mode  out  2  constant +1 (circular)
- o_cd_rot_en  out  1  constant 1
- i_cd_valid  in  1  CORDIC result valid
- i_cd_x / i_cd_y  in  BITS  cos/sin of reduced angle
- i_cd_mode  in  2  returned mode
- i_cd_rot_en  in  1  returned rotation flag
- o_valid  out  1  result available
- o_cos / o_sin  out  BITS  corrected results, Q3.30
- o_tag  out  TAG_W  tag of the head result
- i_ready  in  1  downstream pop when o_valid && i_ready
- o_err  out  1  sticky protocol error

## Operation
- Range reduction on accept:
  - i_angle > PI_HALF: z' = i_angle − PI, neg = 1.
  - i_angle < −PI_HALF: z' = i_angle + PI, neg = 1.
  - Otherwise z' = i_angle, neg = 0.
  - ±PI_HALF exactly is not reduced. Result |z'| ≤ PI_HALF, with no overflow because |i_angle| < 3·PI/2.
- Issue: on accept, register z' onto o_cd_z and pulse o_cd_valid for one cycle. Push {neg, tag} into the sideband FIFO in the same cycle.
- Return: on i_cd_valid, pop the sideband FIFO.
  - If neg: o_cos = −i_cd_x and o_sin = −i_cd_y (two's-complement negate, wraps; unreachable since |result| ≤ ~1).
  - Else pass through unchanged.
  - Push {cos, sin, tag} into the result FIFO.
- Credits:
  - Counter resets to OUT_DEPTH. Accept decrements, result-FIFO pop increments, both together leave it unchanged.
  - o_ready = (credits ≠ 0) && !i_rst.
  - This bounds in-flight jobs plus stored results to OUT_DEPTH, so neither FIFO overflows.
- o_err is set and held until reset on any of:
  - i_cd_valid while the sideband FIFO is empty.
  - i_cd_valid with i_cd_mode ≠ 1 or i_cd_rot_en ≠ 1.
  - The offending result is dropped, and no pop occurs.
- Results leave in issue order. The CORDIC pipeline is strictly in-order.

## Timing
- Accept at edge T. o_cd_valid is high during cycle T+1.
- CORDIC returns i_cd_valid in cycle T+1+L, where L = N_ITERATION+1 of the CORDIC pipeline.
- Result is written at the end of that cycle. o_valid is high one cycle later, so total accept-to-o_valid latency is L+2.
- Throughput: one result per cycle sustained when OUT_DEPTH ≥ L+3 and downstream is always ready.
- Result FIFO is show-ahead: o_cos/o_sin/o_tag are valid whenever o_valid. Push and pop may occur in the same cycle, including when empty+push (pass-through next cycle) and full+pop.
- Reset values:
  - o_ready = 0 while i_rst, 1 the cycle after.
  - o_valid = 0, o_cd_valid = 0, o_cd_z = 0, o_cos/o_sin/o_tag = 0, o_err = 0.
  - Credits = OUT_DEPTH, both FIFOs empty.
- Reset mid-operation: all in-flight and buffered results are discarded. The CORDIC is flushed by the shared i_rst, so no stale i_cd_valid follows.

## Structure
- Add PI and PI_HALF (Q3.30) to the shared CORDIC constants package, next to the existing atan/atanh tables and K constants.
- Sub-module cordic_sync_fifo (parameters WIDTH, DEPTH; show-ahead; full/empty/count), instantiated twice:
  - sideband FIFO, width 1+TAG_W;
  - result FIFO, width 2·BITS+TAG_W.
- Credit counter, reduction and correction logic stay in the top module.

## Test plan
- Angle 0, tag 3 → after L+2 cycles: o_cos ≈ 0x040000000 (1.0), o_sin ≈ 0, o_tag = 3. Tolerance ±2^-10.
- Angle PI (0x0C90FDAA2) → neg path, o_cd_z ≈ 0; o_cos ≈ −1.0 (0x1C0000000), o_sin ≈ 0.
- Angle −4.0 (0x100000000) → o_cd_z ≈ −0.8584; o_cos ≈ −0.6536, o_sin ≈ 0.7568. Angle exactly PI_HALF → o_cd_z = PI_HALF, not reduced.
- OUT_DEPTH = 16, i_ready held 0, i_valid held 1 → exactly 16 accepts, then o_ready = 0. Raise i_ready → 16 results in order, then remaining requests resume.
- 100 back-to-back random angles with random i_ready → all results in order, tags match, o_err = 0. Assert i_rst for 1 cycle mid-stream → o_valid = 0 next cycle, no stale results afterward, credits back to 16.
- Inject i_cd_valid with the sideband FIFO empty → o_err = 1 and held, result FIFO unchanged.
